// File: rtl/branch_unit_ras.sv
// branch_unit_ras
//
// Branch decider with registered Z/C flags, a return-address stack for CALL/RET
// and a saturating taken-branch counter for debug.
//
// Ports:
//   clk_i          - clock, rising edge
//   rst_i          - asynchronous active-high reset
//   op_i           - current instruction opcode
//   ctrl_jmp_i     - sequencer strobe marking the branch-evaluation cycle
//   flag_z_i       - ALU zero result
//   flag_c_i       - ALU carry result
//   flags_we_i     - latch flag_z_i/flag_c_i at the next edge
//   target_i       - operand target address for JMP/BRx/CALL
//   pc_next_i      - return address pushed by CALL
//   branch_o       - load PC from target_o this cycle
//   target_o       - PC load value (RAS top for RET, else target_i)
//   flag_z_o       - registered Z flag
//   flag_c_o       - registered C flag
//   ras_empty_o    - RAS holds no entries
//   ras_full_o     - RAS holds RAS_DEPTH entries
//   fault_o        - sticky RAS overflow/underflow
//   branch_count_o - saturating count of taken branches

module branch_unit_ras #(
    parameter int unsigned     ADDR_W    = 4,
    parameter int unsigned     OP_W      = 4,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter int unsigned     CNT_W     = 8,
    parameter logic [OP_W-1:0] OP_JMP    = 4'b0111,
    parameter logic [OP_W-1:0] OP_BRZ    = 4'b0110,
    parameter logic [OP_W-1:0] OP_BRC    = 4'b1000,
    parameter logic [OP_W-1:0] OP_BRNZ   = 4'b1001,
    parameter logic [OP_W-1:0] OP_CALL   = 4'b1010,
    parameter logic [OP_W-1:0] OP_RET    = 4'b1011
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [OP_W-1:0]   op_i,
    input  logic              ctrl_jmp_i,
    input  logic              flag_z_i,
    input  logic              flag_c_i,
    input  logic              flags_we_i,
    input  logic [ADDR_W-1:0] target_i,
    input  logic [ADDR_W-1:0] pc_next_i,
    output logic              branch_o,
    output logic [ADDR_W-1:0] target_o,
    output logic              flag_z_o,
    output logic              flag_c_o,
    output logic              ras_empty_o,
    output logic              ras_full_o,
    output logic              fault_o,
    output logic [CNT_W-1:0]  branch_count_o
);

    // One extra pointer bit so that "full" (pointer == RAS_DEPTH) is representable
    // without wrapping.
    localparam int unsigned IDX_W = $clog2(RAS_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic                              flag_z_q, flag_z_d;
    logic                              flag_c_q, flag_c_d;
    logic [PTR_W-1:0]                  ptr_q, ptr_d;
    logic [RAS_DEPTH-1:0][ADDR_W-1:0]  ras_q, ras_d;
    logic                              fault_q, fault_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;

    logic             ras_empty;
    logic             ras_full;
    logic             is_call;
    logic             is_ret;
    logic             taken;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] wr_idx;

    assign ras_empty = (ptr_q == '0);
    assign ras_full  = (ptr_q == PTR_W'(RAS_DEPTH));
    // Only meaningful when the stack is non-empty / non-full respectively.
    assign top_idx   = IDX_W'(ptr_q - PTR_W'(1));
    assign wr_idx    = IDX_W'(ptr_q);

    assign is_call = ctrl_jmp_i && (op_i == OP_CALL);
    assign is_ret  = ctrl_jmp_i && (op_i == OP_RET);

    // Branch decision uses only registered flags: a same-edge flag write is not
    // bypassed into the decision.
    always_comb begin
        taken = 1'b0;
        if (ctrl_jmp_i) begin
            case (op_i)
                OP_JMP:  taken = 1'b1;
                OP_BRZ:  taken = flag_z_q;
                OP_BRC:  taken = flag_c_q;
                OP_BRNZ: taken = !flag_z_q;
                OP_CALL: taken = 1'b1;
                OP_RET:  taken = !ras_empty;
                default: taken = 1'b0;
            endcase
        end
    end

    // Reset must silence the PC load immediately, not just after the state clears.
    assign branch_o = taken && !rst_i;

    always_comb begin
        target_o = target_i;
        if (op_i == OP_RET) begin
            target_o = ras_empty ? '0 : ras_q[top_idx];
        end
    end

    // Next-state logic
    always_comb begin
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        ptr_d    = ptr_q;
        ras_d    = ras_q;
        fault_d  = fault_q;
        cnt_d    = cnt_q;

        if (flags_we_i) begin
            flag_z_d = flag_z_i;
            flag_c_d = flag_c_i;
        end

        if (is_call) begin
            if (ras_full) begin
                // Overflow: drop the push but still take the branch.
                fault_d = 1'b1;
            end else begin
                ras_d[wr_idx] = pc_next_i;
                ptr_d         = ptr_q + PTR_W'(1);
            end
        end

        if (is_ret) begin
            if (ras_empty) begin
                fault_d = 1'b1;
            end else begin
                // Popped entry is left in place; only the pointer moves.
                ptr_d = ptr_q - PTR_W'(1);
            end
        end

        if (branch_o && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            ptr_q    <= '0;
            ras_q    <= '0;
            fault_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            ptr_q    <= ptr_d;
            ras_q    <= ras_d;
            fault_q  <= fault_d;
            cnt_q    <= cnt_d;
        end
    end

    assign flag_z_o       = flag_z_q;
    assign flag_c_o       = flag_c_q;
    assign ras_empty_o    = ras_empty;
    assign ras_full_o     = ras_full;
    assign fault_o        = fault_q;
    assign branch_count_o = cnt_q;

endmodule

// File: tb/tb_branch_unit_ras.sv
// Self-checking bench for branch_unit_ras. Two instances share one stimulus
// stream: the default configuration and one with a 2-bit branch counter.
// Expected values come from a queue-based reference model.

module tb_branch_unit_ras;

    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_BRZ  = 4'b0110;
    localparam logic [3:0] OP_BRC  = 4'b1000;
    localparam logic [3:0] OP_BRNZ = 4'b1001;
    localparam logic [3:0] OP_CALL = 4'b1010;
    localparam logic [3:0] OP_RET  = 4'b1011;
    localparam logic [3:0] OP_LDA  = 4'b0000;
    localparam int         DEPTH   = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] op;
    logic       cj, fz, fc, we;
    logic [3:0] tgt, pcn;

    logic       branch, z_o, c_o, empty, full, fault;
    logic [3:0] target;
    logic [7:0] cnt;
    logic       branch2, z2, c2, empty2, full2, fault2;
    logic [3:0] target2;
    logic [1:0] cnt2;

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit         m_z, m_c, m_fault;
    logic [3:0] m_ras[$];
    int         m_n;

    always #5 clk = ~clk;

    branch_unit_ras dut (
        .clk_i(clk), .rst_i(rst), .op_i(op), .ctrl_jmp_i(cj), .flag_z_i(fz), .flag_c_i(fc),
        .flags_we_i(we), .target_i(tgt), .pc_next_i(pcn), .branch_o(branch), .target_o(target),
        .flag_z_o(z_o), .flag_c_o(c_o), .ras_empty_o(empty), .ras_full_o(full),
        .fault_o(fault), .branch_count_o(cnt)
    );

    branch_unit_ras #(.CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .op_i(op), .ctrl_jmp_i(cj), .flag_z_i(fz), .flag_c_i(fc),
        .flags_we_i(we), .target_i(tgt), .pc_next_i(pcn), .branch_o(branch2),
        .target_o(target2), .flag_z_o(z2), .flag_c_o(c2), .ras_empty_o(empty2),
        .ras_full_o(full2), .fault_o(fault2), .branch_count_o(cnt2)
    );

    task automatic chk(input string tag, input string what, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, got, exp);
        end
    endtask

    function automatic bit model_taken();
        if (rst || !cj) return 1'b0;
        case (op)
            OP_JMP, OP_CALL: return 1'b1;
            OP_BRZ:          return m_z;
            OP_BRC:          return m_c;
            OP_BRNZ:         return !m_z;
            OP_RET:          return m_ras.size() != 0;
            default:         return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] model_target();
        if (op != OP_RET) return tgt;
        if (m_ras.size() == 0) return 4'h0;
        return m_ras[m_ras.size()-1];
    endfunction

    function automatic void model_reset();
        m_z = 0; m_c = 0; m_fault = 0; m_n = 0;
        m_ras.delete();
    endfunction

    // Apply one clock edge to the model using the pre-edge state and inputs.
    function automatic void model_edge();
        bit t;
        if (rst) begin
            model_reset();
            return;
        end
        t = model_taken();
        if (cj && op == OP_CALL) begin
            if (m_ras.size() < DEPTH) m_ras.push_back(pcn);
            else m_fault = 1;
        end
        if (cj && op == OP_RET) begin
            if (m_ras.size() > 0) void'(m_ras.pop_back());
            else m_fault = 1;
        end
        if (we) begin
            m_z = fz;
            m_c = fc;
        end
        if (t) m_n++;
    endfunction

    task automatic check_all(input string tag);
        int e8 = (m_n > 255) ? 255 : m_n;
        int e2 = (m_n > 3) ? 3 : m_n;
        chk(tag, "branch", branch, model_taken());
        chk(tag, "target", target, model_target());
        chk(tag, "flag_z", z_o, m_z);
        chk(tag, "flag_c", c_o, m_c);
        chk(tag, "empty", empty, m_ras.size() == 0);
        chk(tag, "full", full, m_ras.size() == DEPTH);
        chk(tag, "fault", fault, m_fault);
        chk(tag, "count", cnt, e8);
        chk(tag, "count_w2", cnt2, e2);
        chk(tag, "branch_w2", branch2, model_taken());
        chk(tag, "target_w2", target2, model_target());
        chk(tag, "misc_w2", {z2, c2, empty2, full2, fault2},
            {m_z, m_c, m_ras.size() == 0, m_ras.size() == DEPTH, m_fault});
    endtask

    // Drive at the falling edge, check combinational outputs, then take the edge.
    task automatic step(input logic [3:0] o, input logic c, input logic z_i, input logic c_i,
                        input logic w, input logic [3:0] t, input logic [3:0] p,
                        input string tag);
        @(negedge clk);
        op = o; cj = c; fz = z_i; fc = c_i; we = w; tgt = t; pcn = p;
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
        #3;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] ops[8];
        ops = '{OP_JMP, OP_BRZ, OP_BRC, OP_BRNZ, OP_CALL, OP_RET, OP_LDA, 4'hF};

        rst = 1'b1; op = OP_JMP; cj = 1'b1; fz = 1'b0; fc = 1'b0; we = 1'b0;
        tgt = 4'hA; pcn = 4'h0;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        model_edge();
        #3;
        rst = 1'b0;

        // 1: unconditional jump; following step sees count=1
        step(OP_JMP, 1, 0, 0, 0, 4'hA, 4'h0, "t1_jmp");
        // 2: Z and C set, then conditional decodes
        step(OP_LDA, 0, 1, 1, 1, 4'h3, 4'h0, "t2_wflags");
        step(OP_BRZ, 1, 0, 0, 0, 4'h5, 4'h0, "t2_brz");
        step(OP_BRNZ, 1, 0, 0, 0, 4'h6, 4'h0, "t2_brnz");
        step(OP_BRZ, 0, 0, 0, 0, 4'h7, 4'h0, "t2_brz_nostrobe");
        step(OP_LDA, 1, 0, 0, 0, 4'h8, 4'h0, "t2_lda");
        step(OP_BRC, 1, 0, 0, 0, 4'h9, 4'h0, "t2_brc");
        // 3: no bypass of a same-edge flag write
        step(OP_LDA, 0, 0, 0, 1, 4'h0, 4'h0, "t3_clrz");
        step(OP_BRZ, 1, 1, 0, 1, 4'hB, 4'h0, "t3_same_edge");
        step(OP_BRZ, 1, 0, 0, 0, 4'hC, 4'h0, "t3_next");
        // 4: fill, overflow, drain
        for (int i = 1; i <= 4; i++) step(OP_CALL, 1, 0, 0, 0, 4'hD, 4'(i), "t4_call");
        step(OP_CALL, 1, 0, 0, 0, 4'hE, 4'h5, "t4_overflow");
        for (int i = 0; i < 4; i++) step(OP_RET, 1, 0, 0, 0, 4'h2, 4'h0, "t4_ret");
        step(OP_LDA, 0, 0, 0, 0, 4'h0, 4'h0, "t4_drained");
        // 5: underflow after reset, fault stays sticky
        pulse_reset("t5_reset");
        step(OP_RET, 1, 0, 0, 0, 4'h9, 4'h0, "t5_ret_empty");
        step(OP_CALL, 1, 0, 0, 0, 4'h4, 4'h7, "t5_call");
        step(OP_CALL, 1, 0, 0, 0, 4'h5, 4'h8, "t5_call");
        step(OP_RET, 1, 0, 0, 0, 4'h1, 4'h0, "t5_ret");
        // 6: saturation of the narrow counter, then reset mid-operation
        pulse_reset("t6_reset");
        for (int i = 0; i < 5; i++) step(OP_JMP, 1, 0, 0, 0, 4'h3, 4'h0, "t6_jmp");
        step(OP_CALL, 1, 1, 1, 1, 4'h6, 4'h2, "t6_busy");
        pulse_reset("t6_midrst");
        step(OP_LDA, 0, 0, 0, 0, 4'h0, 4'h0, "t6_after");
        // Wide counter saturation
        for (int i = 0; i < 260; i++) step(OP_JMP, 1, 0, 0, 0, 4'h1, 4'h0, "sat8");
        step(OP_LDA, 0, 0, 0, 0, 4'h0, 4'h0, "sat8_end");

        // Randomised traffic
        pulse_reset("rnd_start");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulse_reset("rnd_rst");
            end else begin
                logic [3:0] o;
                o = ops[$urandom_range(0, 7)];
                if (o == 4'hF) o = 4'($urandom);
                step(o, ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                     1'($urandom), 4'($urandom), 4'($urandom), "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_unit_ras.md
Name: branch_unit_ras

Overview:
Parametrised successor to the combinational branch decider. It holds the Z/C flag registers, decodes an extended set of conditional branches, and keeps a return-address stack (RAS) for CALL/RET. It sits between the control sequencer (ctrl_jmp_i), the ALU (flags) and the program counter (branch_o/target_o). It also keeps a saturating taken-branch counter for debug.

Parameters:
ADDR_W, 4, width of program addresses (PC, targets, RAS entries)
OP_W, 4, opcode width
RAS_DEPTH, 4, number of RAS entries (power of two, >=2)
CNT_W, 8, taken-branch counter width
OP_JMP, 4'b0111, unconditional jump
OP_BRZ, 4'b0110, branch if Z=1
OP_BRC, 4'b1000, branch if C=1
OP_BRNZ, 4'b1001, branch if Z=0
OP_CALL, 4'b1010, push return address, jump
OP_RET, 4'b1011, pop return address, jump

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
op_i  input  OP_W  current instruction opcode
ctrl_jmp_i  input  1  sequencer strobe: branch-evaluation cycle
flag_z_i  input  1  ALU zero result
flag_c_i  input  1  ALU carry result
flags_we_i  input  1  latch flag_z_i/flag_c_i at next edge
target_i  input  ADDR_W  operand target address for JMP/BRx/CALL
pc_next_i  input  ADDR_W  return address (PC of next instruction)
branch_o  output  1  load PC from target_o this cycle
target_o  output  ADDR_W  PC load value
flag_z_o  output  1  registered Z flag
flag_c_o  output  1  registered C flag
ras_empty_o  output  1  RAS holds 0 entries
ras_full_o  output  1  RAS holds RAS_DEPTH entries
fault_o  output  1  sticky RAS overflow/underflow
branch_count_o  output  CNT_W  saturating count of taken branches

Behaviour:
- Reset (async, immediate): flags=0, RAS pointer=0, RAS entries=0, fault_o=0, branch_count_o=0. ras_empty_o=1, ras_full_o=0. branch_o=0 while rst_i=1.
- Flags: on an edge with flags_we_i=1, flag_z_o<=flag_z_i and flag_c_o<=flag_c_i. Otherwise they hold.
- Branch decision is combinational, zero latency, from op_i, ctrl_jmp_i and the registered flags:
  - ctrl_jmp_i=0 -> branch_o=0 for every opcode.
  - ctrl_jmp_i=1:
    - JMP -> 1.
    - BRZ -> Z.
    - BRC -> C.
    - BRNZ -> !Z.
    - CALL -> 1.
    - RET -> !ras_empty_o.
    - Any other opcode -> 0.
- target_o: for RET it is the RAS top-of-stack (entry at pointer-1). For all other opcodes it equals target_i. When the RAS is empty, RET drives target_o=0.
- Same-edge flags_we_i and branch evaluation: the decision uses pre-edge flags; there is no bypass.
- RAS (LIFO), updated at the edge when ctrl_jmp_i=1:
  - CALL, not full: write pc_next_i at the pointer, then pointer+1.
  - CALL, full: push dropped, contents unchanged, branch still taken, fault_o<=1.
  - RET, not empty: pointer-1. Entry contents are not cleared.
  - RET, empty: no pointer change, branch_o=0, fault_o<=1.
- Pointer width is clog2(RAS_DEPTH)+1. It never wraps; full is pointer==RAS_DEPTH.
- fault_o is sticky and cleared only by rst_i.
- branch_count_o increments at each edge where branch_o=1. It saturates at all-ones and never wraps.
- Reset asserted mid-operation: all state clears immediately, and any in-flight push/pop is lost.

Test Plan:
1. Reset, then JMP with ctrl_jmp_i=1 and target_i=4'hA -> branch_o=1, target_o=4'hA; after the edge, branch_count_o=1.
2. Z: flag_z_i=1 with flags_we_i=1, one edge. Then BRZ with ctrl_jmp_i=1 -> branch_o=1. BRNZ -> branch_o=0. BRZ with ctrl_jmp_i=0 -> branch_o=0. Opcode LDA (4'b0000) with ctrl_jmp_i=1 and C=1 -> branch_o=0.
3. Same edge: flags_we_i=1 with flag_z_i=1 while BRZ is evaluated and the old Z is 0 -> branch_o=0 that cycle. The next BRZ -> branch_o=1.
4. RAS: CALLs with pc_next_i=1,2,3,4 -> ras_full_o=1. A 5th CALL -> branch_o=1, fault_o=1. RETs -> target_o=4,3,2,1, then ras_empty_o=1.
5. RET on an empty RAS after reset -> branch_o=0, target_o=0, fault_o=1. fault_o stays set through later valid CALLs.
6. Run CNT_W=2 with 5 taken jumps -> branch_count_o=3. Assert rst_i between edges -> all outputs return to reset values immediately.
